// File: rtl/mosfet_pkg.sv
// -----------------------------------------------------------------------------
// mosfet_pkg
// Shared definitions for the heater MOSFET gate controller:
//   - state_t   : FSM state encoding, also exported on state_out
//   - FC_*      : fault_code values reported to software
//   - is_drive  : true for the states in which the gate may be driven
// -----------------------------------------------------------------------------
package mosfet_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_RAMP     = 3'd1,
    ST_ON       = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_EXT  = 2'b01;
  localparam logic [1:0] FC_TMO  = 2'b10;

  // RAMP and ON are the only states where PWM runs and the max-on
  // watchdog is armed.
  function automatic logic is_drive(input state_t s);
    return (s == ST_RAMP) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/mosfet_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// mosfet_gate_ctrl_if
// Request/status bundle between the HPS PIO side and the gate controller.
//   en_req        : enable request level (asynchronous to clk)
//   duty_target   : target PWM duty, quasi-static
//   fault_n       : external fault, active-low, asynchronous
//   fault_clr     : one-cycle fault acknowledge
//   gate_out      : registered MOSFET gate drive
//   state_out     : FSM state encoding
//   fault_latched : high while in FAULT
//   fault_code    : 00 none, 01 external, 10 timeout
// master = request side (PIO / bench), slave = controller.
// -----------------------------------------------------------------------------
interface mosfet_gate_ctrl_if #(
  parameter int PWM_W = 8
);
  logic             en_req;
  logic [PWM_W-1:0] duty_target;
  logic             fault_n;
  logic             fault_clr;
  logic             gate_out;
  logic [2:0]       state_out;
  logic             fault_latched;
  logic [1:0]       fault_code;

  modport master (
    output en_req, duty_target, fault_n, fault_clr,
    input  gate_out, state_out, fault_latched, fault_code
  );

  modport slave (
    input  en_req, duty_target, fault_n, fault_clr,
    output gate_out, state_out, fault_latched, fault_code
  );
endinterface

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output (two clk edges of latency)
// RST_VAL lets an active-low input (e.g. a fault line) reset to its
// inactive level so reset release does not look like an event.
// -----------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      // stage 0: may go metastable; stage 1: settled copy
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/mosfet_gate_ctrl.sv
// -----------------------------------------------------------------------------
// mosfet_gate_ctrl
// Turns the HPS single-bit enable into a protected heater gate drive:
// synchronised inputs, soft-start PWM duty ramp, max-on watchdog,
// external fault latch and an enforced cooldown before re-enable.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : mosfet_gate_ctrl_if.slave
//               in : en_req, duty_target, fault_n, fault_clr
//               out: gate_out, state_out, fault_latched, fault_code
//
// Parameters:
//   PWM_W          : PWM counter/duty width, period = 2**PWM_W cycles
//   RAMP_DIV       : cycles per +1 duty step during soft-start (>= 1)
//   MAX_ON_CYCLES  : max continuous RAMP+ON cycles before timeout (>= 1)
//   MIN_OFF_CYCLES : cycles held in COOLDOWN before returning to OFF (>= 1)
// -----------------------------------------------------------------------------
module mosfet_gate_ctrl
  import mosfet_pkg::*;
#(
  parameter int PWM_W          = 8,
  parameter int RAMP_DIV       = 1000,
  parameter int MAX_ON_CYCLES  = 500000000,
  parameter int MIN_OFF_CYCLES = 50000000
) (
  input logic               clk,
  input logic               reset_n,
  mosfet_gate_ctrl_if.slave bus
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int ON_W   = (MAX_ON_CYCLES > 1) ? $clog2(MAX_ON_CYCLES) : 1;
  localparam int OFF_W  = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;

  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MAX_ON_CYCLES - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(MIN_OFF_CYCLES - 1);

  logic en_s;
  logic flt_s;

  state_t            state;
  logic              gate_out;
  logic              fault_latched;
  logic [1:0]        fault_code;
  logic [PWM_W-1:0]  cur_duty;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [ON_W-1:0]   on_cnt;
  logic [OFF_W-1:0]  off_cnt;

  // ---- input synchronisation ------------------------------------------------
  sync2 #(.RST_VAL(1'b0)) u_sync_en (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.en_req),
    .q       (en_s)
  );

  // Fault line resets high (inactive) so reset release is not a fault.
  sync2 #(.RST_VAL(1'b1)) u_sync_flt (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.fault_n),
    .q       (flt_s)
  );

  // ---- control FSM, PWM and registered outputs ------------------------------
  // Fault checks sit ahead of the case statement so they pre-empt every
  // ordinary transition, including en_s falling in the same cycle. The
  // external fault is tested first so it wins over a simultaneous timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_OFF;
      gate_out      <= 1'b0;
      fault_latched <= 1'b0;
      fault_code    <= FC_NONE;
      cur_duty      <= '0;
      pwm_cnt       <= '0;
      ramp_cnt      <= '0;
      on_cnt        <= '0;
      off_cnt       <= '0;
    end else if ((state != ST_FAULT) && !flt_s) begin
      state         <= ST_FAULT;
      gate_out      <= 1'b0;
      fault_latched <= 1'b1;
      fault_code    <= FC_EXT;
    end else if (is_drive(state) && (on_cnt == ON_LAST)) begin
      state         <= ST_FAULT;
      gate_out      <= 1'b0;
      fault_latched <= 1'b1;
      fault_code    <= FC_TMO;
    end else begin
      case (state)
        ST_OFF: begin
          gate_out <= 1'b0;
          cur_duty <= '0;
          pwm_cnt  <= '0;
          if (en_s) begin
            state    <= ST_RAMP;
            ramp_cnt <= '0;
            on_cnt   <= '0;
          end
        end

        ST_RAMP: begin
          if (!en_s) begin
            state    <= ST_COOLDOWN;
            gate_out <= 1'b0;
            off_cnt  <= '0;
          end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            on_cnt   <= on_cnt + 1'b1;
            gate_out <= (pwm_cnt < cur_duty);
            // >= rather than == so a target lowered mid-ramp still
            // hands over to ON; ON then takes the new target directly.
            if (cur_duty >= bus.duty_target) begin
              state    <= ST_ON;
              cur_duty <= bus.duty_target;
            end else if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt <= '0;
              cur_duty <= cur_duty + 1'b1;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end
        end

        ST_ON: begin
          if (!en_s) begin
            state    <= ST_COOLDOWN;
            gate_out <= 1'b0;
            off_cnt  <= '0;
          end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            on_cnt   <= on_cnt + 1'b1;
            gate_out <= (pwm_cnt < cur_duty);
            cur_duty <= bus.duty_target;
          end
        end

        ST_COOLDOWN: begin
          // en_s deliberately ignored here; re-enable only from OFF.
          gate_out <= 1'b0;
          if (off_cnt == OFF_LAST) begin
            state <= ST_OFF;
          end else begin
            off_cnt <= off_cnt + 1'b1;
          end
        end

        ST_FAULT: begin
          gate_out <= 1'b0;
          // Acknowledge only once the request is withdrawn and the fault
          // line is back high, so clearing cannot re-energise the heater.
          if (bus.fault_clr && !en_s && flt_s) begin
            state         <= ST_COOLDOWN;
            fault_latched <= 1'b0;
            fault_code    <= FC_NONE;
            off_cnt       <= '0;
          end
        end

        default: begin
          state    <= ST_OFF;
          gate_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_out      = gate_out;
  assign bus.state_out     = state;
  assign bus.fault_latched = fault_latched;
  assign bus.fault_code    = fault_code;

endmodule

// File: tb/tb_mosfet_gate_ctrl.sv
module tb_mosfet_gate_ctrl;

  localparam int PWM_W   = 4;
  localparam int RDIV    = 2;
  localparam int MAX_ON  = 200;
  localparam int MIN_OFF = 10;
  localparam int PERIOD  = 1 << PWM_W;

  localparam int S_OFF = 0, S_RAMP = 1, S_ON = 2, S_CD = 3, S_FAULT = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mosfet_gate_ctrl_if #(.PWM_W(PWM_W)) bus ();

  mosfet_gate_ctrl #(
    .PWM_W          (PWM_W),
    .RAMP_DIV       (RDIV),
    .MAX_ON_CYCLES  (MAX_ON),
    .MIN_OFF_CYCLES (MIN_OFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---- behavioural model ---------------------------------------------------
  // Timing is tracked as elapsed cycles: m_on_t = cycles since RAMP entry
  // (gives pwm phase and ramp duty by division), m_t = cycles in the
  // current state. ON duty is simply the target seen one edge earlier.
  bit m_en1 = 0, m_en2 = 0, m_flt1 = 1, m_flt2 = 1;
  int m_st = S_OFF, m_t = 0, m_on_t = 0, m_last_tgt = 0, m_code = 0;
  bit m_gate = 0;
  int nx, code_nx, duty;
  bit en_s, flt_s, drv;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en1 = 0; m_en2 = 0; m_flt1 = 1; m_flt2 = 1;
      m_st = S_OFF; m_t = 0; m_on_t = 0; m_last_tgt = 0; m_code = 0;
      m_gate = 0;
    end else begin
      en_s  = m_en2;
      flt_s = m_flt2;
      m_en2 = m_en1;   m_en1  = bus.en_req;
      m_flt2 = m_flt1; m_flt1 = bus.fault_n;
      drv  = (m_st == S_RAMP) || (m_st == S_ON);
      duty = (m_st == S_RAMP) ? m_on_t / RDIV : (m_st == S_ON) ? m_last_tgt : 0;
      nx = m_st;
      code_nx = m_code;
      if (m_st != S_FAULT && !flt_s) begin
        nx = S_FAULT; code_nx = 1;
      end else if (drv && m_on_t == MAX_ON - 1) begin
        nx = S_FAULT; code_nx = 2;
      end else begin
        case (m_st)
          S_OFF:   if (en_s) nx = S_RAMP;
          S_RAMP:  if (!en_s) nx = S_CD; else if (duty >= int'(bus.duty_target)) nx = S_ON;
          S_ON:    if (!en_s) nx = S_CD;
          S_CD:    if (m_t == MIN_OFF - 1) nx = S_OFF;
          default: if (bus.fault_clr && !en_s && flt_s) begin nx = S_CD; code_nx = 0; end
        endcase
      end
      m_gate = drv && (nx == S_RAMP || nx == S_ON) && ((m_on_t % PERIOD) < duty);
      if (nx == S_RAMP && m_st != S_RAMP) m_on_t = 0;
      else if (drv) m_on_t = m_on_t + 1;
      m_t = (nx == m_st) ? m_t + 1 : 0;
      m_last_tgt = int'(bus.duty_target);
      m_st = nx;
      m_code = code_nx;
    end
  end

  // ---- per-cycle compare against the model ---------------------------------
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if ({bus.gate_out, bus.state_out, bus.fault_latched, bus.fault_code} !==
          {m_gate, 3'(m_st), (m_st == S_FAULT), 2'(m_code)}) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t: gate=%0b state=%0d latched=%0b code=%0d, expected gate=%0b state=%0d latched=%0b code=%0d",
                 $time, bus.gate_out, bus.state_out, bus.fault_latched, bus.fault_code,
                 m_gate, m_st, (m_st == S_FAULT), m_code);
      end
    end
  end

  // ---- helpers -------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_gate(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      hi += int'(bus.gate_out);
    end
  endtask

  task automatic recover_from_fault();
    bus.en_req = 1'b0;
    tick(3);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check("recover_cooldown", int'(bus.state_out), S_CD);
    tick(MIN_OFF);
    check("recover_off", int'(bus.state_out), S_OFF);
  endtask

  // ---- directed stimulus ---------------------------------------------------
  int hi;

  initial begin
    bus.en_req      = 1'b0;
    bus.duty_target = '0;
    bus.fault_n     = 1'b1;
    bus.fault_clr   = 1'b0;

    // reset state
    tick(3);
    check("rst_gate", int'(bus.gate_out), 0);
    check("rst_state", int'(bus.state_out), S_OFF);
    check("rst_latched", int'(bus.fault_latched), 0);
    check("rst_code", int'(bus.fault_code), 0);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_state", int'(bus.state_out), S_OFF);

    // 1. soft-start to duty 8
    bus.duty_target = 4'd8;
    bus.en_req = 1'b1;
    tick(2);
    check("ss_off_after_2", int'(bus.state_out), S_OFF);
    tick(1);
    check("ss_ramp_after_3", int'(bus.state_out), S_RAMP);
    tick(16);
    check("ss_still_ramp", int'(bus.state_out), S_RAMP);
    tick(1);
    check("ss_on", int'(bus.state_out), S_ON);
    count_gate(PERIOD, hi);
    check("ss_gate_8_of_16", hi, 8);

    // 2. disable, cooldown, re-enable requested during cooldown
    bus.en_req = 1'b0;
    tick(3);
    check("dis_cooldown", int'(bus.state_out), S_CD);
    check("dis_gate_low", int'(bus.gate_out), 0);
    bus.en_req = 1'b1;
    tick(9);
    check("dis_cd_held", int'(bus.state_out), S_CD);
    tick(1);
    check("dis_off", int'(bus.state_out), S_OFF);
    tick(1);
    check("dis_reramp", int'(bus.state_out), S_RAMP);
    tick(17);
    check("dis_on_again", int'(bus.state_out), S_ON);

    // 3. external fault pulse during ON
    bus.fault_n = 1'b0;
    tick(1);
    bus.fault_n = 1'b1;
    tick(2);
    check("ext_state", int'(bus.state_out), S_FAULT);
    check("ext_code", int'(bus.fault_code), 1);
    check("ext_latched", int'(bus.fault_latched), 1);
    check("ext_gate", int'(bus.gate_out), 0);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check("ext_clr_en_high", int'(bus.state_out), S_FAULT);
    bus.en_req = 1'b0;
    tick(3);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check("ext_clr_cd", int'(bus.state_out), S_CD);
    check("ext_clr_code", int'(bus.fault_code), 0);
    check("ext_clr_latched", int'(bus.fault_latched), 0);
    tick(MIN_OFF);
    check("ext_off", int'(bus.state_out), S_OFF);

    // 4. max-on timeout at duty 15
    bus.duty_target = 4'd15;
    bus.en_req = 1'b1;
    tick(3);
    check("tmo_ramp", int'(bus.state_out), S_RAMP);
    tick(MAX_ON - 1);
    check("tmo_on_before", int'(bus.state_out), S_ON);
    tick(1);
    check("tmo_fault", int'(bus.state_out), S_FAULT);
    check("tmo_code", int'(bus.fault_code), 2);
    count_gate(5, hi);
    check("tmo_gate_zero", hi, 0);
    recover_from_fault();

    // 5. edge duties
    bus.duty_target = 4'd0;
    bus.en_req = 1'b1;
    tick(4);
    check("d0_on", int'(bus.state_out), S_ON);
    count_gate(20, hi);
    check("d0_gate_never", hi, 0);
    bus.duty_target = 4'd15;
    tick(2);
    count_gate(PERIOD, hi);
    check("d15_gate", hi, 15);
    bus.duty_target = 4'd3;
    tick(2);
    check("d3_no_ramp_state", int'(bus.state_out), S_ON);
    count_gate(PERIOD, hi);
    check("d3_gate", hi, 3);
    bus.en_req = 1'b0;
    tick(3 + MIN_OFF);
    check("d_off", int'(bus.state_out), S_OFF);

    // 6. asynchronous reset mid-RAMP
    bus.duty_target = 4'd8;
    bus.en_req = 1'b1;
    tick(3);
    check("rr_ramp", int'(bus.state_out), S_RAMP);
    tick(6);
    #3 reset_n = 1'b0;
    #1;
    check("rr_gate", int'(bus.gate_out), 0);
    check("rr_state", int'(bus.state_out), S_OFF);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(3);
    check("rr_reramp", int'(bus.state_out), S_RAMP);
    tick(16);
    check("rr_full_ramp", int'(bus.state_out), S_RAMP);
    tick(1);
    check("rr_on", int'(bus.state_out), S_ON);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
